reg_bank_2r1w: RTL and testbench
================================

# reg_bank_2r1w

Parametrised successor to the single-port register bank. It provides configurable data width and register count, two synchronous read ports (rs/rt), one write port with same-cycle write-to-read forwarding, an optional hardwired-zero register 0, and a per-register pending-write scoreboard for detecting RAW hazards. It sits between decode (read addresses, issue) and writeback (write port) in the 16-bit datapath.

## Interface
- DATA_WIDTH, 16: register and data-port width in bits.
- ADDR_WIDTH, 2: register address width; NUM_REGS = 2**ADDR_WIDTH.
- ZERO_REG, 0: 1 = register 0 always reads 0, ignores writes, and is never busy; 0 = register 0 is ordinary.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clock.
- WR  in  1  write enable.
- wr_addr  in  ADDR_WIDTH  write destination.
- wr_data  in  DATA_WIDTH  write data.
- rs_addr  in  ADDR_WIDTH  read port A address.
- rt_addr  in  ADDR_WIDTH  read port B address.
- rs_val  out  DATA_WIDTH  registered read data, port A.
- rt_val  out  DATA_WIDTH  registered read data, port B.
- busy_set  in  1  issue strobe; marks busy_addr as pending write.
- busy_addr  in  ADDR_WIDTH  register being issued.
- rs_busy  out  1  registered pending flag for rs_addr.
- rt_busy  out  1  registered pending flag for rt_addr.

## Operation
- Storage: NUM_REGS x DATA_WIDTH registers plus NUM_REGS busy bits.
- Reset (reset=1 at posedge): all registers, busy bits, rs_val, rt_val, rs_busy and rt_busy go to 0. Reset overrides WR, busy_set and reads in the same cycle.
- Write: when WR=1 at posedge, reg[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read: at each posedge, rs_val <= value of reg[rs_addr] as seen after that edge's write. rt_val is handled the same way for rt_addr.
- Forwarding: if WR=1, wr_addr==rs_addr, and the write is not dropped, rs_val <= wr_data. The same rule applies to rt. Both ports may forward in the same cycle.
- ZERO_REG=1: reads of address 0 return 0 and rs_busy/rt_busy for address 0 are 0, regardless of input activity.
- Scoreboard next state for each register i:
  - Set if busy_set=1 and busy_addr==i.
  - Otherwise cleared if WR=1 and wr_addr==i.
  - Otherwise held.
  - Set wins over clear on the same address in the same cycle, because a new issue supersedes the retiring write.
- rs_busy <= next-state busy[rs_addr]; rt_busy <= next-state busy[rt_addr]. Both include same-edge set and clear.
- WR to a register that is not busy is legal: it writes and leaves the bit clear.
- busy_set on an already-busy register is legal: the bit stays set. There is no counting; one write clears it.
- No internal FSM beyond the per-register busy bits; there is no backpressure.

## Timing
- Read latency: 1 cycle. Addresses presented before posedge N appear on rs_val/rt_val after posedge N.
- Write-to-read: a write at edge N is visible on a read sampled at edge N through forwarding, so the effective latency is 0 extra cycles.
- Busy flags follow the same 1-cycle registered timing as the data outputs.
- Outputs hold between edges; there are no combinational paths from inputs to outputs.
- Reset mid-operation discards all register contents and pending flags within one edge. The first read after reset returns 0.

## Test plan
- Reset: write 0x1234 to r1, then hold reset=1 for one edge. Read r1 and r2 -> rs_val=0, rt_val=0, rs_busy=rt_busy=0.
- Basic write/read: WR with r2=0xBEEF at edge 1; rs_addr=2 at edge 2 -> rs_val=0xBEEF after edge 2. rt_addr=3 -> rt_val=0.
- Forwarding: WR r3=0xA5A5 with rs_addr=rt_addr=3 in the same cycle -> both ports read 0xA5A5 after that edge, not the old value.
- ZERO_REG=1: WR r0=0xFFFF and busy_set on r0, then read r0 on both ports -> rs_val=rt_val=0 and busy=0. With ZERO_REG=0, the same read returns 0xFFFF.
- Scoreboard:
  - busy_set r1 at edge 1, then read r1 -> rs_busy=1.
  - WR r1=0x0042 at edge 3 with rs_addr=1 -> rs_val=0x0042 and rs_busy=0.
  - busy_set r1 together with WR r1 in the same cycle -> rs_busy=1.
- Reset mid-operation: r0–r3 busy and loaded with 0x1111–0x4444; assert reset together with WR r2=0x9999 -> all reads return 0, all busy flags 0, and the write is discarded.

Source files
------------

// File: rtl/reg_bank_2r1w_if.sv
// Bus bundle for reg_bank_2r1w: write port, two read ports and the issue/pending-write scoreboard.
// Signal names match the register bank's datasheet so waveforms and checkers line up with it.
interface reg_bank_2r1w_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
);
  // No backpressure anywhere: every input is consumed on the edge it is presented,
  // and every output is a register that is valid from the edge after its inputs.
  logic                  WR;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rs_addr;
  logic [ADDR_WIDTH-1:0] rt_addr;
  logic [DATA_WIDTH-1:0] rs_val;
  logic [DATA_WIDTH-1:0] rt_val;
  logic                  busy_set;
  logic [ADDR_WIDTH-1:0] busy_addr;
  logic                  rs_busy;
  logic                  rt_busy;

  modport master (
    output WR, wr_addr, wr_data, rs_addr, rt_addr, busy_set, busy_addr,
    input  rs_val, rt_val, rs_busy, rt_busy
  );

  modport slave (
    input  WR, wr_addr, wr_data, rs_addr, rt_addr, busy_set, busy_addr,
    output rs_val, rt_val, rs_busy, rt_busy
  );
endinterface

// File: rtl/reg_bank_2r1w.sv
// Two-read/one-write register bank with write-to-read forwarding, optional hardwired
// zero register and a per-register pending-write (RAW hazard) scoreboard.
module reg_bank_2r1w #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int ZERO_REG   = 0
) (
  input  logic           clock,
  input  logic           reset,
  reg_bank_2r1w_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] rs_d;
  logic [DATA_WIDTH-1:0] rt_d;

  // A write to register 0 is dropped entirely when it is hardwired to zero.
  assign wr_ok = bus.WR && !((ZERO_REG != 0) && (bus.wr_addr == '0));

  // Issue beats retire on the same register: the new producer owns the result now.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.WR && (bus.wr_addr == ADDR_WIDTH'(i)))
        busy_d[i] = 1'b0;
      if (bus.busy_set && (bus.busy_addr == ADDR_WIDTH'(i)))
        busy_d[i] = 1'b1;
    end
    if (ZERO_REG != 0)
      busy_d[0] = 1'b0;
  end

  always_comb begin
    rs_d = regs_q[bus.rs_addr];
    rt_d = regs_q[bus.rt_addr];
    if (wr_ok && (bus.wr_addr == bus.rs_addr))
      rs_d = bus.wr_data;
    if (wr_ok && (bus.wr_addr == bus.rt_addr))
      rt_d = bus.wr_data;
    if ((ZERO_REG != 0) && (bus.rs_addr == '0))
      rs_d = '0;
    if ((ZERO_REG != 0) && (bus.rt_addr == '0))
      rt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
      busy_q      <= '0;
      bus.rs_val  <= '0;
      bus.rt_val  <= '0;
      bus.rs_busy <= 1'b0;
      bus.rt_busy <= 1'b0;
    end else begin
      if (wr_ok)
        regs_q[bus.wr_addr] <= bus.wr_data;
      busy_q      <= busy_d;
      bus.rs_val  <= rs_d;
      bus.rt_val  <= rt_d;
      bus.rs_busy <= busy_d[bus.rs_addr];
      bus.rt_busy <= busy_d[bus.rt_addr];
    end
  end
endmodule

// File: tb/tb_reg_bank_2r1w.sv
// Bench for reg_bank_2r1w: drives identical traffic into a ZERO_REG=0 and a ZERO_REG=1
// instance and scores both against a reference model through expected-value queues.
module tb_reg_bank_2r1w;
  localparam int DW = 16;
  localparam int AW = 2;
  localparam int NR = 4;
  localparam int EW = 2 * DW + 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  reg_bank_2r1w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  reg_bank_2r1w_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  reg_bank_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0.slave)
  );
  reg_bank_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1.slave)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] m_regs [2][NR];
  logic [NR-1:0] m_busy [2];
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  int check_cnt = 0;
  int pass_cnt  = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model for one instance; returns {rs_val, rt_val, rs_busy, rt_busy}.
  task automatic model_step(input int d, input logic rst, input logic wr,
                            input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                            input logic bs, input logic [AW-1:0] ba,
                            output logic [EW-1:0] exp);
    logic z;
    logic ok;
    logic [NR-1:0] nb;
    logic [DW-1:0] rv;
    logic [DW-1:0] tv;
    z  = (d == 1);
    ok = wr && !(z && wa == 2'd0);
    nb = m_busy[d];
    if (wr) nb[wa] = 1'b0;
    if (bs) nb[ba] = 1'b1;
    if (z)  nb[0]  = 1'b0;
    rv = (ok && wa == ra) ? wd : m_regs[d][ra];
    tv = (ok && wa == rb) ? wd : m_regs[d][rb];
    if (z && ra == 2'd0) rv = '0;
    if (z && rb == 2'd0) tv = '0;
    if (rst) begin
      exp = '0;
      for (int i = 0; i < NR; i++) m_regs[d][i] = '0;
      m_busy[d] = '0;
    end else begin
      exp = {rv, tv, nb[ra], nb[rb]};
      if (ok) m_regs[d][wa] = wd;
      m_busy[d] = nb;
    end
  endtask

  task automatic compare(input string name, input logic [EW-1:0] e,
                         input logic [DW-1:0] rv, input logic [DW-1:0] tv,
                         input logic rsb, input logic rtb);
    check({name, " rs_val"},  rv,          e[EW-1:DW+2]);
    check({name, " rt_val"},  tv,          e[DW+1:2]);
    check({name, " rs_busy"}, DW'(rsb),    DW'(e[1]));
    check({name, " rt_busy"}, DW'(rtb),    DW'(e[0]));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic wr, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                      input logic [AW-1:0] rb, input logic bs, input logic [AW-1:0] ba);
    logic [EW-1:0] e;
    @(negedge clock);
    reset         = rst;
    bus0.WR       = wr;  bus1.WR       = wr;
    bus0.wr_addr  = wa;  bus1.wr_addr  = wa;
    bus0.wr_data  = wd;  bus1.wr_data  = wd;
    bus0.rs_addr  = ra;  bus1.rs_addr  = ra;
    bus0.rt_addr  = rb;  bus1.rt_addr  = rb;
    bus0.busy_set = bs;  bus1.busy_set = bs;
    bus0.busy_addr = ba; bus1.busy_addr = ba;
    model_step(0, rst, wr, wa, wd, ra, rb, bs, ba, e); exp_q0.push_back(e);
    model_step(1, rst, wr, wa, wd, ra, rb, bs, ba, e); exp_q1.push_back(e);
    @(posedge clock);
    #1;
    if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
      check_cnt++;
      $display("FAIL exp_q: got empty queue expected entry");
    end else begin
      compare("z0", exp_q0.pop_front(), bus0.rs_val, bus0.rt_val, bus0.rs_busy, bus0.rt_busy);
      compare("z1", exp_q1.pop_front(), bus1.rs_val, bus1.rt_val, bus1.rs_busy, bus1.rt_busy);
    end
  endtask

  task automatic rd(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    step(1'b0, 1'b0, 2'd0, 16'h0000, ra, rb, 1'b0, 2'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NR; i++) m_regs[d][i] = '0;
      m_busy[d] = '0;
    end

    // Reset state, then write r1 and reset it away.
    step(1'b1, 1'b0, 2'd0, 16'h0000, 2'd1, 2'd2, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd1, 16'h1234, 2'd1, 2'd2, 1'b0, 2'd0);
    step(1'b1, 1'b0, 2'd0, 16'h0000, 2'd1, 2'd2, 1'b0, 2'd0);
    rd(2'd1, 2'd2);

    // Basic write then read; forwarding on both ports.
    step(1'b0, 1'b1, 2'd2, 16'hBEEF, 2'd0, 2'd0, 1'b0, 2'd0);
    rd(2'd2, 2'd3);
    step(1'b0, 1'b1, 2'd3, 16'h5555, 2'd0, 2'd0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd3, 16'hA5A5, 2'd3, 2'd3, 1'b0, 2'd0);
    rd(2'd3, 2'd2);

    // Register 0: hardwired in dut1, ordinary in dut0.
    step(1'b0, 1'b1, 2'd0, 16'hFFFF, 2'd0, 2'd0, 1'b1, 2'd0);
    rd(2'd0, 2'd0);
    step(1'b0, 1'b1, 2'd0, 16'hFFFF, 2'd0, 2'd0, 1'b0, 2'd0);

    // Scoreboard: set, retire with forwarding, set+retire same cycle, double set.
    step(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd0, 1'b1, 2'd1);
    rd(2'd1, 2'd2);
    step(1'b0, 1'b1, 2'd1, 16'h0042, 2'd1, 2'd0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd1, 16'h0077, 2'd1, 2'd1, 1'b1, 2'd1);
    step(1'b0, 1'b0, 2'd0, 16'h0000, 2'd1, 2'd0, 1'b1, 2'd1);
    step(1'b0, 1'b1, 2'd1, 16'h0088, 2'd1, 2'd1, 1'b0, 2'd0);

    // Reset mid-operation discards contents, pending flags and the concurrent write.
    step(1'b0, 1'b1, 2'd0, 16'h1111, 2'd0, 2'd1, 1'b1, 2'd0);
    step(1'b0, 1'b1, 2'd1, 16'h2222, 2'd0, 2'd1, 1'b1, 2'd1);
    step(1'b0, 1'b1, 2'd2, 16'h3333, 2'd2, 2'd3, 1'b1, 2'd2);
    step(1'b0, 1'b1, 2'd3, 16'h4444, 2'd2, 2'd3, 1'b1, 2'd3);
    rd(2'd0, 2'd1);
    step(1'b1, 1'b1, 2'd2, 16'h9999, 2'd2, 2'd3, 1'b1, 2'd2);
    rd(2'd0, 2'd1);
    rd(2'd2, 2'd3);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)),
           DW'($urandom_range(0, 16'hFFFF)),
           AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)),
           ($urandom_range(0, 2) == 0), AW'($urandom_range(0, NR - 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
